cla_sum_decoder: RTL and testbench

//   Inverse of the decomposed CLA adder: given sum s and operand a/c_in, recovers operand
//   b = s - a - c_in. Operand recovery runs through the same two-level split as the adder:

---
 rtl/cla_sum_decoder.sv | 79 +++++++
 tb/tb_cla_sum_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cla_sum_decoder.sv
// cla_sum_decoder: recovers b = s - a - c_in through a two-stage borrow-lookahead pipeline
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake for s, a, c_in
//   s, a, c_in             sum word, known operand, known carry-in
//   out_valid/out_ready    output handshake for b, range_err
//   b, range_err           recovered operand, sum unreachable from a/c_in
//   err_cnt                saturating count of transferred outputs with range_err
module cla_sum_decoder #(
  parameter int NBIT = 7,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBIT:0]        s,
  input  logic [NBIT-1:0]      a,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBIT-1:0]      b,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic v1, v2, c1, adv2, load1, t, u;
  logic [NBIT:0] a_ext, g1, p1, x1;
  logic [NBIT+1:0] bw, d;
  assign a_ext = {1'b0, a};
  assign in_ready = !v1 || !v2 || out_ready;
  assign load1 = in_valid && in_ready;
  assign adv2 = v1 && (!v2 || out_ready);
  assign out_valid = v2;
  // Each borrow is a flat sum of generate terms gated by the propagates above them,
  // so no borrow depends on a previously computed borrow.
  always_comb begin
    bw = '0;
    t = 1'b0;
    u = 1'b0;
    bw[0] = c1;
    for (int i = 0; i <= NBIT; i++) begin
      t = c1;
      for (int k = 0; k <= i; k++) t = t & p1[k];
      for (int j = 0; j <= i; j++) begin
        u = g1[j];
        for (int k = j + 1; k <= i; k++) u = u & p1[k];
        t = t | u;
      end
      bw[i+1] = t;
    end
    d = {bw[NBIT+1], x1 ^ bw[NBIT:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      c1 <= 1'b0;
      g1 <= '0;
      p1 <= '0;
      x1 <= '0;
      b <= '0;
      range_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (load1) begin
        g1 <= ~s & a_ext;
        p1 <= ~(s ^ a_ext);
        x1 <= s ^ a_ext;
        c1 <= c_in;
      end
      v1 <= load1 || (v1 && !adv2);
      if (adv2) begin
        b <= d[NBIT-1:0];
        range_err <= d[NBIT+1] | d[NBIT];
      end
      v2 <= adv2 || (v2 && !out_ready);
      if (v2 && out_ready && range_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cla_sum_decoder.sv
// tb_cla_sum_decoder: vector table, stall/reset sequences and random stream against an arithmetic model
module tb_cla_sum_decoder;
  logic clk, rst, in_valid, in_ready, c_in, out_valid, out_ready, range_err;
  logic [7:0] s, err_cnt;
  logic [6:0] a, b;
  logic in_ready2, out_valid2, range_err2;
  logic [6:0] b2;
  logic [1:0] err_cnt2;
  int n_tests = 0, n_fail = 0, n_out = 0, m_cnt = 0, m_cnt2 = 0;
  logic mon_en = 0, stall_prev = 0;
  logic [7:0] stall_val, e;
  logic [7:0] q[$];

  cla_sum_decoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s(s), .a(a),
    .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .b(b), .range_err(range_err), .err_cnt(err_cnt));
  cla_sum_decoder #(.NBIT(7), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready2), .s(s), .a(a), .c_in(c_in), .out_valid(out_valid2), .out_ready(out_ready),
    .b(b2), .range_err(range_err2), .err_cnt(err_cnt2));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] sv, input logic [6:0] av, input logic cv);
    int dv;
    dv = int'(sv) - int'(av) - int'(cv);
    return {(dv < 0 || dv > 127), 7'(dv)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_cnt_w2", err_cnt2, m_cnt2);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {range_err, b}, stall_val);
    end
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_cnt2 = 0;
      stall_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", {range_err, b}, 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("out_data", {range_err, b}, e);
          if (e[7]) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(s, a, c_in));
      stall_prev = out_valid && !out_ready;
      stall_val = {range_err, b};
    end
  end

  typedef struct {
    logic [7:0] s;
    logic [6:0] a;
    logic c;
    logic [6:0] b;
    logic e;
  } vec_t;

  vec_t tab[10];
  logic [7:0] ws[4];
  logic [6:0] wa[4];
  logic [6:0] bv;
  logic hs;
  int acc, cycles, base;

  initial begin
    tab[0] = '{8'd200, 7'd100, 1'b0, 7'd100, 1'b0};
    tab[1] = '{8'd3, 7'd5, 1'b0, 7'h7E, 1'b1};
    tab[2] = '{8'd255, 7'd0, 1'b0, 7'h7F, 1'b1};
    tab[3] = '{8'd128, 7'd0, 1'b1, 7'd127, 1'b0};
    tab[4] = '{8'd0, 7'd0, 1'b1, 7'h7F, 1'b1};
    tab[5] = '{8'd0, 7'd127, 1'b1, 7'd0, 1'b1};
    tab[6] = '{8'd255, 7'd127, 1'b1, 7'd127, 1'b0};
    tab[7] = '{8'd10, 7'd3, 1'b1, 7'd6, 1'b0};
    tab[8] = '{8'd0, 7'd0, 1'b0, 7'd0, 1'b0};
    tab[9] = '{8'd200, 7'd50, 1'b0, 7'h16, 1'b1};
    rst = 1; in_valid = 0; out_ready = 0; s = 0; a = 0; c_in = 0;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_b", b, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    mon_en = 1;
    cyc();
    foreach (tab[i]) begin
      in_valid = 1; out_ready = 1; s = tab[i].s; a = tab[i].a; c_in = tab[i].c;
      @(negedge clk) chk("tab_in_ready", in_ready, 1);
      cyc();
      in_valid = 0;
      @(negedge clk) chk("tab_lat1_valid", out_valid, 0);
      cyc();
      @(negedge clk);
      chk("tab_lat2_valid", out_valid, 1);
      chk("tab_b", b, tab[i].b);
      chk("tab_err", range_err, tab[i].e);
      cyc();
    end
    @(negedge clk);
    chk("tab_err_cnt", err_cnt, 5);
    chk("tab_err_cnt_sat", err_cnt2, 3);
    cyc();
    for (int k = 0; k < 4; k++) begin
      wa[k] = 7'(10 * k + 3);
      ws[k] = 8'(20 * k + 40) + 8'(wa[k]);
    end
    base = n_out; acc = 0; out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = acc < 4; s = ws[acc % 4]; a = wa[acc % 4]; c_in = 0;
      @(negedge clk);
      hs = in_valid && in_ready;
      chk("stream_in_ready", in_ready, k < 2);
      cyc();
      if (hs) acc++;
    end
    chk("stream_accepts_stalled", acc, 2);
    out_ready = 1; cycles = 0;
    while (acc < 4 && cycles < 20) begin
      in_valid = 1; s = ws[acc]; a = wa[acc]; c_in = 0;
      @(negedge clk) hs = in_ready;
      cyc();
      cycles++;
      if (hs) acc++;
    end
    in_valid = 0; cycles = 0;
    while ((q.size() != 0 || out_valid) && cycles < 20) begin cyc(); cycles++; end
    chk("stream_out_count", n_out - base, 4);
    in_valid = 1; out_ready = 0; s = 8'd90; a = 7'd20; c_in = 1;
    cyc(); cyc();
    in_valid = 0;
    @(negedge clk) chk("full_in_ready", in_ready, 0);
    rst = 1; in_valid = 1; out_ready = 1;
    cyc();
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    cyc();
    @(negedge clk) chk("midrst_dropped", out_valid, 0);
    cyc();
    acc = 0; cycles = 0;
    a = 7'($urandom); bv = 7'($urandom); c_in = 1'($urandom); s = 8'(a) + 8'(bv) + 8'(c_in);
    while (acc < 10000 && cycles < 40000) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk) hs = in_valid && in_ready;
      cyc();
      cycles++;
      if (hs) begin
        acc++;
        a = 7'($urandom); bv = 7'($urandom); c_in = 1'($urandom);
        s = (acc % 4 == 0) ? 8'($urandom) : 8'(a) + 8'(bv) + 8'(c_in);
      end
    end
    chk("rand_accepts", acc, 10000);
    in_valid = 0; out_ready = 1; cycles = 0;
    while ((q.size() != 0 || out_valid) && cycles < 20) begin cyc(); cycles++; end
    chk("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
